// File: rtl/frame_pack_pkg.sv
// Shared definitions for the SDRAM frame packer/unpacker pair: bit positions
// of every colour field inside the two packed 16-bit words, the default frame
// size and the read-side FSM state encoding.
package frame_pack_pkg;

    localparam int FRAME_PIXELS_DEF = 384000;   // 800 x 480

    // word1 = {gray[7], G[9:5], B[9:2], gray[6:5]}
    localparam int W1_GRAY7_BIT  = 15;
    localparam int W1_G95_HI     = 14;
    localparam int W1_G95_LO     = 10;
    localparam int W1_B92_HI     = 9;
    localparam int W1_B92_LO     = 2;
    localparam int W1_GRAY65_HI  = 1;
    localparam int W1_GRAY65_LO  = 0;

    // word2 = {gray[4], G[4:3], gray[3:2], G[2], R[9:2], gray[1:0]}
    localparam int W2_GRAY4_BIT  = 15;
    localparam int W2_G43_HI     = 14;
    localparam int W2_G43_LO     = 13;
    localparam int W2_GRAY32_HI  = 12;
    localparam int W2_GRAY32_LO  = 11;
    localparam int W2_G2_BIT     = 10;
    localparam int W2_R92_HI     = 9;
    localparam int W2_R92_LO     = 2;
    localparam int W2_GRAY10_HI  = 1;
    localparam int W2_GRAY10_LO  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } fu_state_t;

endpackage

// File: rtl/frame_word_unpack.sv
// Combinational unpack of one word pair into 10-bit RGB and 8-bit gray.
// Only the top 8 bits of each colour travel through SDRAM; the two LSBs are
// restored as zero.
module frame_word_unpack
    import frame_pack_pkg::*;
(
    input  logic [15:0] word1,
    input  logic [15:0] word2,
    output logic [9:0]  r,
    output logic [9:0]  g,
    output logic [9:0]  b,
    output logic [7:0]  gray
);

    assign r = {word2[W2_R92_HI:W2_R92_LO], 2'b00};
    assign b = {word1[W1_B92_HI:W1_B92_LO], 2'b00};
    assign g = {word1[W1_G95_HI:W1_G95_LO],
                word2[W2_G43_HI:W2_G43_LO],
                word2[W2_G2_BIT],
                2'b00};
    assign gray = {word1[W1_GRAY7_BIT],
                   word1[W1_GRAY65_HI:W1_GRAY65_LO],
                   word2[W2_GRAY4_BIT],
                   word2[W2_GRAY32_HI:W2_GRAY32_LO],
                   word2[W2_GRAY10_HI:W2_GRAY10_LO]};

endmodule

// File: rtl/frame_unpacker.sv
// Read-side frame unpacker: issues lockstep reads to both SDRAM read FIFOs on
// display requests, unpacks the returned word pair two cycles later, tracks
// frame position and records FIFO underflow.
//
// Optional build macro FRAME_UNPACKER_UFLOW_STATS_EN: when defined, the
// per-frame saturating underflow counter is built; otherwise oUflowCount is
// tied to zero and only the sticky oUnderflow flag remains.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for iFrameStart; requests ignored, no FIFO reads
// STREAM | serving requests, counting pixels toward the terminal count
// DONE   | last pixel accepted; oFrameDone high this cycle, requests dropped
module frame_unpacker
    import frame_pack_pkg::*;
#(
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int CNT_W        = 19,
    parameter int UFLOW_W      = 16
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iFrameStart,
    input  logic               iReq,
    input  logic               iFifoEmpty,
    input  logic [15:0]        iFifoData1,
    input  logic [15:0]        iFifoData2,
    output logic               oFifoRead,
    output logic [9:0]         oR,
    output logic [9:0]         oG,
    output logic [9:0]         oB,
    output logic [7:0]         oGray,
    output logic               oValid,
    output logic               oFrameDone,
    output logic               oUnderflow,
    output logic [UFLOW_W-1:0] oUflowCount
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    fu_state_t        state;
    logic [CNT_W-1:0] pix_cnt;
    logic             req_ok;
    logic             req_uflow;
    logic             s1_valid;
    logic             s1_uflow;
    logic [9:0]       unp_r;
    logic [9:0]       unp_g;
    logic [9:0]       unp_b;
    logic [7:0]       unp_gray;

    // A request is only honoured while streaming; an empty FIFO turns it
    // into an underflow that still occupies a pixel slot.
    assign req_ok    = (state == STREAM) && iReq;
    assign req_uflow = req_ok && iFifoEmpty;
    assign oFifoRead = req_ok && !iFifoEmpty;

    // Frame FSM with pixel counter, frame-done pulse and sticky underflow flag.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            oFrameDone <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            if (iFrameStart) begin
                oUnderflow <= 1'b0;
            end
            // Placed after the clear so an underflow on a resync cycle
            // belongs to the new frame.
            if (req_uflow) begin
                oUnderflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (iFrameStart) begin
                        state   <= STREAM;
                        pix_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (iFrameStart) begin
                        // Resync: a coincident request becomes pixel 0.
                        pix_cnt <= iReq ? CNT_W'(1) : '0;
                    end else if (iReq) begin
                        if (pix_cnt == LAST_PIX) begin
                            state      <= DONE;
                            pix_cnt    <= '0;
                            oFrameDone <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // A frame start landing on the done cycle is not lost.
                    if (iFrameStart) begin
                        state   <= STREAM;
                        pix_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pix_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FRAME_UNPACKER_UFLOW_STATS_EN
    logic [UFLOW_W-1:0] uflow_cnt;

    // Per-frame underflow count, saturating, restarted by each frame start.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            uflow_cnt <= '0;
        end else if (iFrameStart) begin
            uflow_cnt <= req_uflow ? UFLOW_W'(1) : '0;
        end else if (req_uflow && (uflow_cnt != {UFLOW_W{1'b1}})) begin
            uflow_cnt <= uflow_cnt + UFLOW_W'(1);
        end
    end

    assign oUflowCount = uflow_cnt;
`else
    assign oUflowCount = '0;
`endif

    // Stage 1: remember which cycle's FIFO data is worth capturing; the FIFO
    // presents its word one cycle after the read strobe.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s1_valid <= 1'b0;
            s1_uflow <= 1'b0;
        end else begin
            s1_valid <= req_ok;
            s1_uflow <= req_uflow;
        end
    end

    frame_word_unpack u_unpack (
        .word1 (iFifoData1),
        .word2 (iFifoData2),
        .r     (unp_r),
        .g     (unp_g),
        .b     (unp_b),
        .gray  (unp_gray)
    );

    // Stage 2: register the unpacked pixel; underflowed slots emit black so
    // the display stays aligned, idle cycles hold the last pixel.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oValid <= 1'b0;
            oR     <= '0;
            oG     <= '0;
            oB     <= '0;
            oGray  <= '0;
        end else begin
            oValid <= s1_valid;
            if (s1_valid) begin
                if (s1_uflow) begin
                    oR    <= '0;
                    oG    <= '0;
                    oB    <= '0;
                    oGray <= '0;
                end else begin
                    oR    <= unp_r;
                    oG    <= unp_g;
                    oB    <= unp_b;
                    oGray <= unp_gray;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_unpacker.sv
// Self-checking bench for frame_unpacker with a 16-pixel frame. Expected
// pixels are queued when a request is driven and compared when oValid fires.
module tb_frame_unpacker;

    localparam int FP = 16;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iFrameStart;
    logic        iReq;
    logic        iFifoEmpty;
    logic [15:0] iFifoData1;
    logic [15:0] iFifoData2;
    logic        oFifoRead;
    logic [9:0]  oR, oG, oB;
    logic [7:0]  oGray;
    logic        oValid;
    logic        oFrameDone;
    logic        oUnderflow;
    logic [15:0] oUflowCount;

    typedef struct {
        int         due;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic [7:0] gray;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        rd_pend = 1'b0;
    logic [15:0] pend1   = '0;
    logic [15:0] pend2   = '0;

`ifdef FRAME_UNPACKER_UFLOW_STATS_EN
    localparam logic [15:0] EXP_UFLOW3 = 16'd3;
`else
    localparam logic [15:0] EXP_UFLOW3 = 16'd0;
`endif

    frame_unpacker #(.FRAME_PIXELS(FP), .CNT_W(5), .UFLOW_W(16)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iFrameStart (iFrameStart),
        .iReq        (iReq),
        .iFifoEmpty  (iFifoEmpty),
        .iFifoData1  (iFifoData1),
        .iFifoData2  (iFifoData2),
        .oFifoRead   (oFifoRead),
        .oR          (oR),
        .oG          (oG),
        .oB          (oB),
        .oGray       (oGray),
        .oValid      (oValid),
        .oFrameDone  (oFrameDone),
        .oUnderflow  (oUnderflow),
        .oUflowCount (oUflowCount)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic exp_t exp_pix(input logic [15:0] w1, input logic [15:0] w2, input int due);
        exp_t e;
        e.due  = due;
        e.gray = {w1[15], w1[1:0], w2[15], w2[12:11], w2[1:0]};
        e.g    = {w1[14:10], w2[14:13], w2[10], 2'b00};
        e.b    = {w1[9:2], 2'b00};
        e.r    = {w2[9:2], 2'b00};
        return e;
    endfunction

    // Output monitor: every oValid must match the oldest queued pixel on its
    // due cycle; a queued pixel that is overdue is reported as missing.
    always @(negedge iClk) begin
        if (oValid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid cyc=%0d got rgb=%h/%h/%h gray=%h, expected no output",
                         cyc, oR, oG, oB, oGray);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.due !== cyc || oR !== e.r || oG !== e.g || oB !== e.b || oGray !== e.gray) begin
                    n_fail++;
                    $display("FAIL pixel cyc=%0d got rgb=%h/%h/%h gray=%h, expected cyc=%0d rgb=%h/%h/%h gray=%h",
                             cyc, oR, oG, oB, oGray, e.due, e.r, e.g, e.b, e.gray);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_valid cyc=%0d got oValid=%b, expected pixel due cyc=%0d",
                     cyc, oValid, sb[0].due);
            void'(sb.pop_front());
        end
    end

    // One clock of stimulus. acc says whether the DUT should accept the
    // request; FIFO data for a read is presented on the following cycle.
    task automatic step(input logic fs, input logic req, input logic empty,
                        input logic acc, input logic exp_done,
                        input logic [15:0] w1, input logic [15:0] w2);
        logic exp_rd;
        iFifoData1  = rd_pend ? pend1 : 16'($urandom);
        iFifoData2  = rd_pend ? pend2 : 16'($urandom);
        iFrameStart = fs;
        iReq        = req;
        iFifoEmpty  = empty;
        exp_rd      = acc && !empty;
        if (acc) begin
            if (empty) sb.push_back(exp_pix(16'h0000, 16'h0000, cyc + 2));
            else       sb.push_back(exp_pix(w1, w2, cyc + 2));
        end
        @(negedge iClk);
        n_tests++;
        if (oFifoRead !== exp_rd) begin
            n_fail++;
            $display("FAIL fifo_read cyc=%0d got %b expected %b", cyc, oFifoRead, exp_rd);
        end
        n_tests++;
        if (oFrameDone !== exp_done) begin
            n_fail++;
            $display("FAIL frame_done cyc=%0d got %b expected %b", cyc, oFrameDone, exp_done);
        end
        rd_pend = exp_rd;
        pend1   = w1;
        pend2   = w2;
        @(posedge iClk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic test_reset;
        iRst_n = 1'b0; iFrameStart = 0; iReq = 0; iFifoEmpty = 0;
        iFifoData1 = '0; iFifoData2 = '0;
        repeat (2) @(posedge iClk);
        #1;
        iReq = 1'b1;
        #1;
        n_tests++;
        if ({oValid, oFrameDone, oUnderflow, oFifoRead} !== 4'b0000 || oUflowCount !== 16'd0 ||
            {oR, oG, oB, oGray} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b fd=%b uf=%b rd=%b cnt=%0d rgbg=%h expected all zero",
                     oValid, oFrameDone, oUnderflow, oFifoRead, oUflowCount, {oR, oG, oB, oGray});
        end
        iReq = 1'b0;
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;
        step(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF);   // IDLE ignores requests
        step(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_unpack_ones;
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 16'hFFFF, 16'hFFFF);
        idle(2);
    endtask

    task automatic test_unpack_patterns;
        step(0, 1, 0, 1, 0, 16'h8003, 16'h0000);
        step(0, 1, 0, 1, 0, 16'h0000, 16'h9803);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            step(0, 1, 0, 1, 0, a, b);
        end
        idle(2);
    endtask

    task automatic test_underflow;
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 1, 0, 16'h1234, 16'h5678);
        step(0, 1, 0, 1, 0, 16'hA5A5, 16'h5A5A);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 16'hFFFF, 16'hFFFF);
        step(0, 1, 0, 1, 0, 16'hFFFF, 16'hFFFF);
        n_tests++;
        if (oUnderflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_flag got %b expected 1", oUnderflow);
        end
        n_tests++;
        if (oUflowCount !== EXP_UFLOW3) begin
            n_fail++;
            $display("FAIL uflow_count got %0d expected %0d", oUflowCount, EXP_UFLOW3);
        end
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        n_tests++;
        if (oUnderflow !== 1'b0 || oUflowCount !== 16'd0) begin
            n_fail++;
            $display("FAIL underflow_clear got flag=%b count=%0d expected 0/0", oUnderflow, oUflowCount);
        end
        idle(2);
    endtask

    task automatic test_frame_done;
        // Frame start coinciding with a request in STREAM: that request is pixel 0.
        step(1, 1, 0, 1, 0, 16'h0F0F, 16'hF0F0);
        for (int i = 1; i < FP; i++) step(0, 1, 0, 1, 0, 16'($urandom), 16'($urandom));
        step(0, 1, 0, 0, 1, 16'hFFFF, 16'hFFFF);   // 17th request dropped in DONE
        step(0, 0, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF);   // back in IDLE
        idle(2);
    endtask

    task automatic test_resync;
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0, 16'($urandom), 16'($urandom));
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < FP; i++) step(0, 1, 0, 1, 0, 16'($urandom), 16'($urandom));
        step(0, 0, 0, 0, 1, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 16'h0, 16'h0);
        idle(1);
    endtask

    task automatic test_reset_mid;
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 1, 1, 0, 16'h0, 16'h0);
        step(0, 1, 0, 1, 0, 16'hFFFF, 16'hFFFF);
        idle(2);
        n_tests++;
        if (oUnderflow !== 1'b1 || oR !== 10'h3FC) begin
            n_fail++;
            $display("FAIL pre_reset got uf=%b r=%h expected 1/3fc", oUnderflow, oR);
        end
        iRst_n = 1'b0;
        step(0, 0, 0, 0, 0, 16'h0, 16'h0);
        iRst_n = 1'b1;
        n_tests++;
        if ({oValid, oFrameDone, oUnderflow} !== 3'b000 || oUflowCount !== 16'd0 ||
            {oR, oG, oB, oGray} !== 38'd0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b fd=%b uf=%b cnt=%0d rgbg=%h expected all zero",
                     oValid, oFrameDone, oUnderflow, oUflowCount, {oR, oG, oB, oGray});
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF);
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 1, 0, 16'h8003, 16'h9803);
        idle(3);
    endtask

    initial begin
        test_reset;
        test_unpack_ones;
        test_unpack_patterns;
        test_underflow;
        test_frame_done;
        test_resync;
        test_reset_mid;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_unpacker.md
Name: frame_unpacker

Overview:
- Read-side counterpart of the camera pipeline's SDRAM write packing: pulls paired 16-bit words from the two SDRAM read-port FIFOs and unpacks them into 10-bit RGB plus the embedded 8-bit gray value for the LCD/display path.
- Issues FIFO read strobes on display pixel requests, compensates the one-cycle FIFO read latency, and tracks frame position.
- Handles FIFO underflow and frame resynchronisation deterministically.

Parameters:
- FRAME_PIXELS, 384000, pixels per frame (800x480); pixel counter terminal count.
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W >= FRAME_PIXELS.
- UFLOW_W, 16, underflow counter width; saturating.

Ports:
- iClk  in  1  pixel clock.
- iRst_n  in  1  reset, synchronous, active-low.
- iFrameStart  in  1  one-cycle pulse at start of each display frame (vsync edge).
- iReq  in  1  display requests one pixel this cycle.
- iFifoEmpty  in  1  either read FIFO empty; both FIFOs are read in lockstep.
- iFifoData1  in  16  read-FIFO 1 word, valid one cycle after oFifoRead.
- iFifoData2  in  16  read-FIFO 2 word, same timing.
- oFifoRead  out  1  read strobe to both FIFOs.
- oR, oG, oB  out  10 each  unpacked colour.
- oGray  out  8  unpacked gray.
- oValid  out  1  output pixel valid.
- oFrameDone  out  1  one-cycle pulse after the last pixel of a frame.
- oUnderflow  out  1  sticky, set on any request that found the FIFO empty; cleared by iFrameStart.
- oUflowCount  out  UFLOW_W  count of underflowed requests this frame.

Behaviour:
- Packing format, fixed:
  - word1 = {gray[7], G[9:5], B[9:2], gray[6:5]}.
  - word2 = {gray[4], G[4:3], gray[3:2], G[2], R[9:2], gray[1:0]}.
  - Unpacked R, G and B carry 0 in bits [1:0]; G[9:2] are reassembled as {w1[14:10], w2[14:13], w2[10]}.
- Reset (iRst_n=0 at an iClk edge): state IDLE; all outputs 0; counters 0. Reset mid-frame abandons the frame; no oFrameDone is issued.
- FSM IDLE:
  - oFifoRead=0.
  - iReq is ignored; oValid=0.
  - iFrameStart -> STREAM with pixel count 0.
- FSM STREAM:
  - Each cycle with iReq=1 advances the pixel count by 1.
  - If iFifoEmpty=0: oFifoRead=iReq in the same cycle (combinational from iReq and iFifoEmpty, gated by state).
  - If iFifoEmpty=1: oFifoRead=0, the pixel is an underflow, oUnderflow is set, and oUflowCount increments, saturating at all-ones.
  - Request accepted at the count reaching FRAME_PIXELS-1 -> state DONE.
- FSM DONE:
  - oFrameDone=1 for exactly one cycle, then IDLE.
  - The final pixel's output still emerges two cycles after its request.
- Latency:
  - Request at cycle t -> FIFO data at t+1 -> oR/oG/oB/oGray registered and oValid=1 at t+2.
  - Underflowed pixels also give oValid=1 at t+2, with RGB=0 and gray=0 (black), keeping display alignment.
- iFrameStart while in STREAM: resync. Pixel count resets to 0; the in-flight pipeline drains normally (outputs still appear); oUnderflow and oUflowCount clear. No oFrameDone.
- iFrameStart in the same cycle as iReq in STREAM: the request counts as pixel 0 of the new frame.
- iReq is not honoured in DONE; a request there is dropped, oValid=0, and no read is issued.
- oValid=0 on every cycle without a pipelined request; data outputs hold their last value.

Optional Feature:
- Macro FRAME_UNPACKER_UFLOW_STATS_EN.
- Defined: oUflowCount implemented as specified.
- Undefined: counter not synthesised; oUflowCount tied to 0; oUnderflow flag retained.

Decomposition:
- Shared package frame_pack_pkg holds:
  - word-field bit-position constants for both words;
  - FRAME_PIXELS default;
  - FSM state enum (IDLE, STREAM, DONE).
- The packer side reuses the same constants.
- One sub-module, frame_word_unpack: purely combinational from {word1, word2} to {R, G, B, gray}, instantiated before the output register.

Test Plan:
- Reset then iFrameStart, 4 requests with FIFO words w1=16'hFFFF, w2=16'hFFFF -> oValid at t+2 for each; oGray=8'hFF; oR=oG=oB=10'h3FC.
- Words w1=16'h8003, w2=16'h0000 -> oGray=8'hE0, RGB=0; w1=0, w2=16'h9803 -> oGray=8'h1F.
- iFifoEmpty=1 on 3 requests mid-frame -> oFifoRead=0, oValid with black pixels, oUnderflow=1, oUflowCount=3; next iFrameStart clears both.
- FRAME_PIXELS=16 override, 16 continuous requests -> oFrameDone pulses once, one cycle after the last request; a 17th request gives no oFifoRead.
- iFrameStart at pixel 7 of 16 -> count restarts; oFrameDone only after 16 further requests; the two in-flight outputs still appear.
- iRst_n=0 mid-STREAM for 1 cycle -> all outputs 0 next cycle; requests ignored until iFrameStart.
